// File: rtl/cmd_stream_arbiter.sv
// Two-source command stream arbiter.
// Picks one AXI-Stream source per frame (round-robin on ties), checks that the
// first word of the frame is MAGIC, then passes the frame through with zero
// latency. A bad header drains the frame silently. A source that stalls
// mid-frame is cut off with a synthetic ABORT_WORD beat and its remainder is
// drained. Every rejected or aborted frame pulses drop_pulse and bumps a
// saturating drop counter.
module cmd_stream_arbiter #(
    parameter logic [31:0] MAGIC          = 32'h57575757,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ABORT_WORD     = 32'hDEADDEAD
) (
    input  logic        gtx_clk_bufg,
    input  logic        gtx_resetn,
    input  logic [31:0] s0_axis_tdata,
    input  logic        s0_axis_tvalid,
    input  logic        s0_axis_tlast,
    output logic        s0_axis_tready,
    input  logic [31:0] s1_axis_tdata,
    input  logic        s1_axis_tvalid,
    input  logic        s1_axis_tlast,
    output logic        s1_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic [1:0]  grant,
    output logic        drop_pulse,
    output logic [15:0] drop_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_PASS  = 3'd2,
        ST_ABORT = 3'd3,
        ST_DROP  = 3'd4
    } state_e;

    localparam logic [1:0]  GNT_NONE = 2'b00;
    localparam logic [1:0]  GNT_S0   = 2'b01;
    localparam logic [1:0]  GNT_S1   = 2'b10;
    // Counter value at which a starved PASS frame is given up on.
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 32'd1);

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] drop_count_q;

    logic [31:0] sel_tdata_s;
    logic        sel_tvalid_s;
    logic        sel_tlast_s;
    logic        sel_tready_s;
    logic [1:0]  pick_s;

    // Route the granted source onto a common set of signals.
    always_comb begin
        if (grant_q == GNT_S1) begin
            sel_tdata_s  = s1_axis_tdata;
            sel_tvalid_s = s1_axis_tvalid;
            sel_tlast_s  = s1_axis_tlast;
        end else if (grant_q == GNT_S0) begin
            sel_tdata_s  = s0_axis_tdata;
            sel_tvalid_s = s0_axis_tvalid;
            sel_tlast_s  = s0_axis_tlast;
        end else begin
            sel_tdata_s  = 32'h0000_0000;
            sel_tvalid_s = 1'b0;
            sel_tlast_s  = 1'b0;
        end
    end

    // Round-robin choice: on a tie the source not served last wins.
    always_comb begin
        if (s0_axis_tvalid && s1_axis_tvalid) begin
            pick_s = (last_grant_q == GNT_S1) ? GNT_S0 : GNT_S1;
        end else if (s0_axis_tvalid) begin
            pick_s = GNT_S0;
        end else if (s1_axis_tvalid) begin
            pick_s = GNT_S1;
        end else begin
            pick_s = GNT_NONE;
        end
    end

    // Next-state, grant, timeout counter and stream outputs.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        m_axis_tdata  = 32'h0000_0000;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        sel_tready_s  = 1'b0;
        drop_pulse    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_s != GNT_NONE) begin
                    grant_d      = pick_s;
                    last_grant_d = pick_s;
                    cnt_d        = 16'd0;
                    state_d      = ST_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (sel_tvalid_s && (sel_tdata_s == MAGIC)) begin
                    m_axis_tdata  = sel_tdata_s;
                    m_axis_tvalid = 1'b1;
                    m_axis_tlast  = sel_tlast_s;
                    sel_tready_s  = m_axis_tready;
                    if (m_axis_tready) begin
                        cnt_d   = 16'd0;
                        state_d = sel_tlast_s ? ST_IDLE : ST_PASS;
                        grant_d = sel_tlast_s ? GNT_NONE : grant_q;
                    end else begin
                        state_d = ST_HDR;
                    end
                end else if (sel_tvalid_s) begin
                    // Bad header: swallow the word and flag the frame as dropped.
                    sel_tready_s = 1'b1;
                    drop_pulse   = 1'b1;
                    cnt_d        = 16'd0;
                    state_d      = sel_tlast_s ? ST_IDLE : ST_DROP;
                    grant_d      = sel_tlast_s ? GNT_NONE : grant_q;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_PASS: begin
                m_axis_tdata  = sel_tdata_s;
                m_axis_tvalid = sel_tvalid_s;
                m_axis_tlast  = sel_tlast_s;
                sel_tready_s  = m_axis_tready;
                if (sel_tvalid_s && m_axis_tready) begin
                    cnt_d = 16'd0;
                    if (sel_tlast_s) begin
                        state_d = ST_IDLE;
                        grant_d = GNT_NONE;
                    end else begin
                        state_d = ST_PASS;
                    end
                end else if (sel_tvalid_s) begin
                    // Backpressure from the decoder is not source starvation.
                    cnt_d = cnt_q;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_ABORT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_ABORT: begin
                m_axis_tdata  = ABORT_WORD;
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                if (m_axis_tready) begin
                    drop_pulse = 1'b1;
                    state_d    = ST_DROP;
                end else begin
                    state_d = ST_ABORT;
                end
            end
            ST_DROP: begin
                sel_tready_s = 1'b1;
                if (sel_tvalid_s && sel_tlast_s) begin
                    cnt_d   = 16'd0;
                    state_d = ST_IDLE;
                    grant_d = GNT_NONE;
                end else if (sel_tvalid_s) begin
                    cnt_d = 16'd0;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    // Only the granted source ever sees tready.
    assign s0_axis_tready = (grant_q == GNT_S0) && sel_tready_s;
    assign s1_axis_tready = (grant_q == GNT_S1) && sel_tready_s;
    assign grant          = grant_q;
    assign drop_count     = drop_count_q;

    // FSM state, grant ownership and timeout counter registers.
    always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn) begin
        if (!gtx_resetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_NONE;
            last_grant_q <= GNT_S1;
            cnt_q        <= 16'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    // Saturating count of dropped and aborted frames.
    always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn) begin
        if (!gtx_resetn) begin
            drop_count_q <= 16'd0;
        end else if (drop_pulse && (drop_count_q != 16'hFFFF)) begin
            drop_count_q <= drop_count_q + 16'd1;
        end else begin
            drop_count_q <= drop_count_q;
        end
    end

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
// Bench for cmd_stream_arbiter: frame table plus hand-written corner sequences.
// Expected output beats go into a scoreboard queue when a frame is queued and
// are checked by a monitor as the DUT hands them over.
module tb_cmd_stream_arbiter;

    localparam logic [31:0] MAGIC  = 32'h57575757;
    localparam logic [31:0] ABORTW = 32'hDEADDEAD;
    localparam int          TO     = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
    logic        s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
    logic        s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [1:0]  grant;
    logic        drop_pulse;
    logic [15:0] drop_count;

    cmd_stream_arbiter #(.MAGIC(MAGIC), .TIMEOUT_CYCLES(TO), .ABORT_WORD(ABORTW)) dut (
        .gtx_clk_bufg(clk), .gtx_resetn(rst_n),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid),
        .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid),
        .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .grant(grant), .drop_pulse(drop_pulse), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] data; logic last; } beat_t;
    typedef struct packed { logic [31:0] data; logic last; logic [1:0] grant; } exp_t;
    typedef struct {
        int          src;
        logic [31:0] hdr;
        logic [31:0] base;
        int          len;
        int          nexp;
        logic [1:0]  exp_grant;
        logic [15:0] exp_dc;
    } vec_t;

    beat_t s0_q[$];
    beat_t s1_q[$];
    exp_t  exp_q[$];
    exp_t  mon_e;
    vec_t  vecs[5];
    logic  pat[0:5];

    int   total = 0;
    int   bad = 0;
    int   sent0 = 0;
    int   sent1 = 0;
    int   stall0 = -1;
    int   pulses = 0;
    int   k;
    bit   hs0, hs1, found;
    logic [1:0] g_seen = 2'b00;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Queue a frame on a source; the first nexp beats are expected on m_axis.
    task automatic push_frame(int src, logic [31:0] hdr, logic [31:0] base, int len, int nexp);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = (i == 0) ? hdr : (base + ((i == 1) ? 32'hA : 32'(i)));
            b.last = (i == len - 1);
            if (src == 0) s0_q.push_back(b);
            else          s1_q.push_back(b);
            if (i < nexp) exp_q.push_back({b.data, b.last, (src == 0) ? 2'b01 : 2'b10});
        end
    endtask

    task automatic wait_idle(string name, int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (s0_q.size() == 0 && s1_q.size() == 0 && exp_q.size() == 0 && grant == 2'b00)
                done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s actual=busy required=idle (exp left %0d)", name, exp_q.size());
        end
    endtask

    // Source 0 driver: advance on a handshake seen at the previous negedge.
    initial begin
        s0_axis_tvalid = 1'b0; s0_axis_tdata = 32'h0; s0_axis_tlast = 1'b0;
        forever begin
            @(negedge clk);
            hs0 = s0_axis_tvalid && s0_axis_tready;
            @(posedge clk); #1;
            if (hs0 && s0_q.size() > 0) begin
                void'(s0_q.pop_front());
                sent0++;
            end
            if (s0_q.size() > 0 && sent0 != stall0) begin
                s0_axis_tvalid = 1'b1;
                s0_axis_tdata  = s0_q[0].data;
                s0_axis_tlast  = s0_q[0].last;
            end else begin
                s0_axis_tvalid = 1'b0; s0_axis_tdata = 32'h0; s0_axis_tlast = 1'b0;
            end
        end
    end

    // Source 1 driver.
    initial begin
        s1_axis_tvalid = 1'b0; s1_axis_tdata = 32'h0; s1_axis_tlast = 1'b0;
        forever begin
            @(negedge clk);
            hs1 = s1_axis_tvalid && s1_axis_tready;
            @(posedge clk); #1;
            if (hs1 && s1_q.size() > 0) begin
                void'(s1_q.pop_front());
                sent1++;
            end
            if (s1_q.size() > 0) begin
                s1_axis_tvalid = 1'b1;
                s1_axis_tdata  = s1_q[0].data;
                s1_axis_tlast  = s1_q[0].last;
            end else begin
                s1_axis_tvalid = 1'b0; s1_axis_tdata = 32'h0; s1_axis_tlast = 1'b0;
            end
        end
    end

    // Output monitor: scoreboard compare, grant tracking and pulse counting.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (grant != 2'b00) g_seen = grant;
                if (drop_pulse) pulses++;
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat actual=%h required=none", m_axis_tdata);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("beat_data", m_axis_tdata, mon_e.data);
                        check("beat_last", {31'b0, m_axis_tlast}, {31'b0, mon_e.last});
                        check("beat_grant", {30'b0, grant}, {30'b0, mon_e.grant});
                    end
                end
            end
        end
    end

    initial begin
        m_axis_tready = 1'b0;
        vecs[0] = '{0, MAGIC,        32'h0000_0000, 8, 8, 2'b01, 16'd0};
        vecs[1] = '{1, 32'h12345678, 32'h1100_0000, 4, 0, 2'b10, 16'd1};
        vecs[2] = '{1, MAGIC,        32'h2200_0000, 1, 1, 2'b10, 16'd1};
        vecs[3] = '{0, 32'hCAFEF00D, 32'h3300_0000, 1, 0, 2'b01, 16'd2};
        vecs[4] = '{1, MAGIC,        32'h4400_0000, 5, 5, 2'b10, 16'd2};
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
        pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {25'b0, m_axis_tvalid, m_axis_tlast, s0_axis_tready, s1_axis_tready, grant, drop_pulse},
              32'h0);
        check("reset_drop_count", {16'b0, drop_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        m_axis_tready = 1'b1;

        // Table of single frames
        for (int v = 0; v < 5; v++) begin
            g_seen = 2'b00;
            push_frame(vecs[v].src, vecs[v].hdr, vecs[v].base, vecs[v].len, vecs[v].nexp);
            wait_idle("vec_idle", 100);
            check("vec_grant", {30'b0, g_seen}, {30'b0, vecs[v].exp_grant});
            check("vec_drop_count", {16'b0, drop_count}, {16'b0, vecs[v].exp_dc});
            check("vec_pulses", 32'(pulses), {16'b0, vecs[v].exp_dc});
        end

        // Both sources continuously valid: last grant was s1, so s0 goes first
        push_frame(0, MAGIC, 32'h5000_0000, 4, 4);
        push_frame(1, MAGIC, 32'h6000_0000, 4, 4);
        push_frame(0, MAGIC, 32'h5100_0000, 4, 4);
        push_frame(1, MAGIC, 32'h6100_0000, 4, 4);
        wait_idle("rr_idle", 200);
        check("rr_drop_count", {16'b0, drop_count}, 32'd2);

        // Starved source: abort beat after TO starved cycles, remainder drained
        sent0 = 0;
        stall0 = 3;
        push_frame(0, MAGIC, 32'h7000_0000, 8, 3);
        exp_q.push_back({ABORTW, 1'b1, 2'b01});
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (sent0 == 3) found = 1'b1;
        end
        check("stall_reached", {31'b0, found}, 32'd1);
        found = 1'b0;
        for (k = 1; k < 40; k++) begin
            if (m_axis_tvalid && m_axis_tdata == ABORTW) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort_latency", 32'(k), 32'd17);
        stall0 = -1;
        wait_idle("abort_idle", 100);
        check("abort_drop_count", {16'b0, drop_count}, 32'd3);
        check("abort_pulses", 32'(pulses), 32'd3);

        // Decoder backpressure pattern during pass-through
        push_frame(0, MAGIC, 32'h8000_0000, 8, 8);
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            m_axis_tready = pat[c % 6];
            @(negedge clk);
            if (s0_q.size() == 0 && exp_q.size() == 0 && grant == 2'b00) break;
        end
        m_axis_tready = 1'b1;
        wait_idle("bp_idle", 50);
        check("bp_drop_count", {16'b0, drop_count}, 32'd3);

        // Reset in the middle of a pass-through frame
        sent0 = 0;
        stall0 = 3;
        push_frame(0, MAGIC, 32'h9000_0000, 8, 3);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (sent0 == 3) found = 1'b1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              {25'b0, m_axis_tvalid, m_axis_tlast, s0_axis_tready, s1_axis_tready, grant, drop_pulse},
              32'h0);
        check("midreset_tdata", m_axis_tdata, 32'h0);
        check("midreset_drop_count", {16'b0, drop_count}, 32'h0);
        s0_q.delete();
        stall0 = -1;
        sent0 = 0;
        pulses = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // New s1 frame after release: arbitrated on the first edge seeing it
        g_seen = 2'b00;
        push_frame(1, MAGIC, 32'hA000_0000, 3, 3);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (s1_axis_tvalid) found = 1'b1;
        end
        check("post_reset_idle_grant", {30'b0, grant}, 32'd0);
        @(negedge clk);
        check("post_reset_grant", {30'b0, grant}, 32'd2);
        wait_idle("post_reset_idle", 100);
        check("post_reset_g_seen", {30'b0, g_seen}, 32'd2);
        check("post_reset_drop_count", {16'b0, drop_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmd_stream_arbiter.md
CMD_STREAM_ARBITER -- requirements
Module: cmd_stream_arbiter

Interface
REQ-001 SHALL have parameter MAGIC, default 32'h57575757, the required first word of every command frame.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, the number of source-starved cycles before a frame is aborted (legal range 2..65535).
REQ-003 SHALL have parameter ABORT_WORD, default 32'hDEADDEAD, the tdata value of the synthetic terminating beat.
REQ-004 SHALL use one clock and an asynchronous active-low reset:
- gtx_clk_bufg  in  1  clock for all logic
- gtx_resetn  in  1  asynchronous active-low reset
REQ-005 SHALL have the remaining ports:
- s0_axis_tdata  in  32  source 0 (Ethernet RX command) data
- s0_axis_tvalid  in  1  source 0 valid
- s0_axis_tlast  in  1  source 0 end of frame
- s0_axis_tready  out  1  source 0 ready
- s1_axis_tdata/tvalid/tlast/tready  in/in/in/out  32/1/1/1  source 1 (local host command), same meaning as s0
- m_axis_tdata  out  32  data to the command decoder
- m_axis_tvalid  out  1  valid to the decoder
- m_axis_tlast  out  1  end of frame to the decoder
- m_axis_tready  in  1  decoder ready
- grant  out  2  one-hot owner of the current frame (00 when idle)
- drop_pulse  out  1  one-cycle pulse on each rejected or aborted frame
- drop_count  out  16  saturating count of rejected plus aborted frames

Function
REQ-006 SHALL implement the states IDLE, HDR, PASS, ABORT and DROP.
REQ-007 In IDLE: all treadys 0, m_axis_tvalid 0, grant 00; on any source tvalid, SHALL latch the grant and enter HDR on the next cycle (1-cycle arbitration latency).
REQ-008 Arbitration SHALL be frame-granular round-robin: if both sources are valid, grant the one not granted last; last_grant resets to s1 so s0 wins the first tie; a single valid source always wins.
REQ-009 The grant SHALL remain fixed from HDR until the frame ends (tlast handshake, drop or abort); the other source sees tready=0 throughout.
REQ-010 HDR, granted word == MAGIC: forward combinationally (m_tdata=s_tdata, m_tvalid=s_tvalid, s_tready=m_tready); on handshake go to PASS, or to IDLE if tlast.
REQ-011 HDR, granted word != MAGIC while tvalid: m_tvalid=0, s_tready=1 (word discarded), drop_pulse=1; go to DROP, or to IDLE if tlast.
REQ-012 PASS: zero-latency pass-through as in REQ-010; tlast handshake returns to IDLE.
REQ-013 The timeout counter SHALL clear on every source handshake and on entry to PASS, increment in PASS only while the granted s_tvalid=0, hold while s_tvalid=1 and m_tready=0, and enter ABORT when it reaches TIMEOUT_CYCLES-1.
REQ-014 ABORT: s_tready=0; m_tvalid=1, m_tlast=1, m_tdata=ABORT_WORD until m_tready; on that handshake pulse drop_pulse and go to DROP.
REQ-015 DROP: granted s_tready=1, m_tvalid=0; discard beats until the tlast handshake, then go to IDLE with the grant released.
REQ-016 drop_count SHALL increment by 1 per drop_pulse and saturate at 16'hFFFF.
REQ-017 m_axis_tlast SHALL equal the granted s_tlast in HDR/PASS, 1 in ABORT, and 0 otherwise.

Reset
REQ-018 On gtx_resetn=0 (asynchronous): state=IDLE, grant=00, last_grant=s1, counter=0, drop_count=0, drop_pulse=0, all tready/tvalid outputs 0; an in-flight frame is abandoned with no terminating beat.
REQ-019 After reset release, the first arbitration SHALL happen on the first rising edge that sees a valid source.

Verification
REQ-020 s0 sends the 8-word frame {57575757, 0000000A, 2..7}, m_tready=1 -> identical 8 words on m_axis, tlast on word 8, grant=01 during the frame, drop_count=0.
REQ-021 s0 and s1 both continuously valid with 4-word MAGIC frames -> grant alternates 01,10,01,10 per frame with no interleaving within a frame.
REQ-022 s1 frame whose first word is 12345678 (4 words) -> nothing on m_axis, s1 drained, one drop_pulse, drop_count=1.
REQ-023 TIMEOUT_CYCLES=16; s0 sends MAGIC plus 2 words then holds tvalid=0 -> ABORT beat DEADDEAD with tlast after 16 starved cycles; remaining s0 beats up to tlast discarded; drop_count=1.
REQ-024 m_tready toggled in the pattern 1,0,0,1,0,1 during PASS with s0 continuously valid -> no loss or duplication and no timeout.
REQ-025 Reset asserted mid-PASS -> all outputs 0 immediately; after release a new s1 frame is granted with grant=10 and the abandoned s0 remainder gets no special treatment.
